// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC engine: mode encodings, FSM states,
// arctangent table and inverse-gain constant. Optional NORM state: CORDIC_GAIN_COMP_EN.
package cordic_pkg;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        NORM,
        DONE
    } state_t;

    // 1/K as an unsigned Q0.40 fraction (~0.6072529350)
    localparam logic [39:0] INV_GAIN = 40'd667681663043;

    // atan(2^-i) in Q3.29 radians; beyond i=9 the angle equals 2^-i to this precision
    function automatic logic [31:0] atan_q29(input int unsigned i);
        case (i)
            0:       return 32'd421657428;
            1:       return 32'd248918915;
            2:       return 32'd131521918;
            3:       return 32'd66762579;
            4:       return 32'd33510843;
            5:       return 32'd16771758;
            6:       return 32'd8387925;
            7:       return 32'd4194219;
            8:       return 32'd2097141;
            9:       return 32'd1048575;
            default: return (i <= 29) ? (32'd1 << (29 - i)) : 32'd0;
        endcase
    endfunction

    // Table entry rescaled to Q3.(width-3), rounded to nearest
    function automatic logic [32:0] atan_scaled(input int unsigned i, input int unsigned width);
        logic [32:0] t;
        t = {1'b0, atan_q29(i)};
        if (width < 32)
            t = t + (33'd1 << (31 - width));
        return t >> (32 - width);
    endfunction

    // 1/K rescaled to Q1.(width+2), rounded to nearest
    function automatic logic [35:0] inv_gain_coef(input int unsigned width);
        int unsigned f;
        logic [40:0] t;
        f = width + 2;
        t = {1'b0, INV_GAIN} + (41'd1 << (39 - f));
        return 36'(t >> (40 - f));
    endfunction

endpackage

// File: rtl/cordic_iter_step.sv
// One combinational CORDIC micro-rotation; the engine reuses a single instance
// every RUN cycle with the current iteration index.
module cordic_iter_step
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH+1:0] x,
    input  logic [WIDTH+1:0] y,
    input  logic [WIDTH:0]   z,
    input  logic [5:0]       i,
    input  logic             mode,
    output logic [WIDTH+1:0] x_next,
    output logic [WIDTH+1:0] y_next,
    output logic [WIDTH:0]   z_next
);

    localparam int ZW = WIDTH + 1;

    logic signed [WIDTH+1:0] xs, ys, x_sh, y_sh;
    logic        [WIDTH:0]   ang;
    logic                    up;

    always_comb begin
        xs   = x;
        ys   = y;
        x_sh = xs >>> i;
        y_sh = ys >>> i;
        ang  = ZW'(atan_scaled({26'd0, i}, WIDTH));
        // up means d = +1: z non-negative when rotating, y negative when vectoring
        up   = (mode == MODE_ROT) ? ~z[WIDTH] : y[WIDTH+1];
        if (up) begin
            x_next = xs - y_sh;
            y_next = ys + x_sh;
            z_next = z - ang;
        end else begin
            x_next = xs + y_sh;
            y_next = ys - x_sh;
            z_next = z + ang;
        end
    end

endmodule

// File: rtl/cordic_engine.sv
// Iterative rotation/vectoring CORDIC with valid/ready handshakes, one operation
// in flight. Optional gain-compensation NORM state: CORDIC_GAIN_COMP_EN.
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res1,
    output logic [WIDTH-1:0] res2
);

    localparam int         IW   = WIDTH + 2;
    localparam logic [5:0] LAST = 6'(ITER - 1);

    state_t          state, state_next;
    logic            mode_r;
    logic [IW-1:0]   x_r, y_r, x_step, y_step;
    logic [WIDTH:0]  z_r, z_step;
    logic [5:0]      i_r;
    logic            last;

    cordic_iter_step #(.WIDTH(WIDTH)) u_step (
        .x      (x_r),
        .y      (y_r),
        .z      (z_r),
        .i      (i_r),
        .mode   (mode_r),
        .x_next (x_step),
        .y_next (y_step),
        .z_next (z_step)
    );

    assign last = (i_r == LAST);

    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH+2:0] v);
        if (v[WIDTH+2:WIDTH-1] == '0 || v[WIDTH+2:WIDTH-1] == '1)
            return v[WIDTH-1:0];
        return v[WIDTH+2] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [35:0] INV_K = inv_gain_coef(WIDTH);

    // x * (1/K) with the Q1.IW coefficient, rounded half-up back to integer LSBs
    function automatic logic [WIDTH+2:0] scale(input logic [IW-1:0] v);
        logic signed [2*IW:0] p, half;
        half         = '0;
        half[IW-1]   = 1'b1;
        p            = $signed(v) * $signed(INV_K[IW:0]);
        p            = p + half;
        return (WIDTH+3)'(p >>> IW);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid)
                    state_next = RUN;
            end
            RUN: begin
                if (last) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_next = NORM;
`else
                    state_next = DONE;
`endif
                end
            end
            NORM: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r <= MODE_ROT;
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            i_r    <= '0;
            res1   <= '0;
            res2   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_r <= mode;
                        x_r    <= {{2{x_in[WIDTH-1]}}, x_in};
                        y_r    <= {{2{y_in[WIDTH-1]}}, y_in};
                        z_r    <= (mode == MODE_VEC) ? '0 : {z_in[WIDTH-1], z_in};
                        i_r    <= '0;
                    end
                end
                RUN: begin
                    x_r <= x_step;
                    y_r <= y_step;
                    z_r <= z_step;
                    i_r <= i_r + 6'd1;
`ifdef CORDIC_GAIN_COMP_EN
`else
                    if (last) begin
                        res1 <= sat({x_step[IW-1], x_step});
                        res2 <= (mode_r == MODE_ROT) ? sat({y_step[IW-1], y_step})
                                                     : z_step[WIDTH-1:0];
                    end
`endif
                end
                NORM: begin
`ifdef CORDIC_GAIN_COMP_EN
                    res1 <= sat(scale(x_r));
                    res2 <= (mode_r == MODE_ROT) ? sat(scale(y_r)) : z_r[WIDTH-1:0];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine (WIDTH=16, ITER=14): directed vectors,
// handshake stall, mid-run reset and randomized operations against a reference model.
module tb_cordic_engine;

    localparam int WIDTH = 16;
    localparam int ITER  = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT   = ITER + 2;
`else
    localparam int LAT   = ITER + 1;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, mode, out_valid, out_ready;
    logic [15:0] x_in, y_in, z_in, res1, res2;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int atan_lsb [ITER];

    always #5 clk = ~clk;

    cordic_engine #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res1      (res1),
        .res2      (res2)
    );

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Reference: textbook CORDIC on unbounded integers, gain left in, saturated at the end
    function automatic void model(input bit vec, input int x0, input int y0, input int z0,
                                  output int r1, output int r2);
        longint x, y, z, xn;
        logic [15:0] zt;
        bit up;
        x = x0;
        y = y0;
        z = vec ? 0 : z0;
        for (int i = 0; i < ITER; i++) begin
            up = vec ? (y < 0) : (z >= 0);
            xn = up ? x - (y >>> i) : x + (y >>> i);
            y  = up ? y + (x >>> i) : y - (x >>> i);
            x  = xn;
            z  = up ? z - atan_lsb[i] : z + atan_lsb[i];
        end
        zt = z[15:0];
        r1 = clamp16(x);
        r2 = vec ? s16(zt) : clamp16(y);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        int diff;
        diff = obs - exp;
        checks++;
        assert ((diff <= tol && diff >= -tol) === 1'b1) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic start_op(input bit m, input int xv, input int yv, input int zv);
        int n;
        n = 0;
        @(negedge clk);
        mode     = m;
        x_in     = 16'(xv);
        y_in     = 16'(yv);
        z_in     = 16'(zv);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Called just after the acceptance edge; lat counts cycles until out_valid
    task automatic wait_result(output int r1, output int r2, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_timeout", int'(out_valid), 1);
        r1 = s16(res1);
        r2 = s16(res2);
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input bit m, input int xv, input int yv,
                          input int zv, output int r1, output int r2);
        int lat, e1, e2;
        start_op(m, xv, yv, zv);
        wait_result(r1, r2, lat);
        model(m, xv, yv, zv, e1, e2);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_res1"}, r1, e1);
        check({tag, "_res2"}, r2, e2);
        ack();
    endtask

    initial begin
        int r1, r2, lat, e1, e2, n;
        int xa, ya, za, xb, yb;

        for (int i = 0; i < ITER; i++)
            atan_lsb[i] = $rtoi($floor($atan(1.0 / (2.0 ** i)) * 8192.0 + 0.5));

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_res1", s16(res1), 0);
        check("rst_res2", s16(res2), 0);
        check("rst_in_ready", int'(in_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);

        // Directed vectors with loose tolerance to the ideal mathematical answers
        run_op("rot_zero", 1'b0, 'h26DD, 0, 0, r1, r2);
        check_tol("rot_zero_x", r1, 'h4000, 4);
        check_tol("rot_zero_y", r2, 0, 4);
        run_op("rot_pi4", 1'b0, 'h26DD, 0, 'h1922, r1, r2);
        check_tol("rot_pi4_x", r1, 'h2D41, 4);
        check_tol("rot_pi4_y", r2, 'h2D41, 4);
        run_op("vec_2000", 1'b1, 'h2000, 'h2000, 0, r1, r2);
        check_tol("vec_2000_mag", r1, 'h4A86, 4);
        check_tol("vec_2000_ang", r2, 'h1922, 4);
        run_op("vec_sat", 1'b1, 'h4000, 'h4000, 0, r1, r2);
        check("vec_sat_mag", r1, 'h7FFF);
        check_tol("vec_sat_ang", r2, 'h1922, 4);

        // Request B is raised during A's RUN and must wait for A's handshake
        xa = int'($urandom_range(20000)) - 10000;
        ya = int'($urandom_range(20000)) - 10000;
        za = int'($urandom_range(20000)) - 10000;
        xb = int'($urandom_range(30000));
        yb = int'($urandom_range(40000)) - 20000;
        start_op(1'b0, xa, ya, za);
        repeat (3) @(negedge clk);
        mode     = 1'b1;
        x_in     = 16'(xb);
        y_in     = 16'(yb);
        z_in     = 16'h1234;
        in_valid = 1'b1;
        check("run_in_ready", int'(in_ready), 0);
        wait_result(r1, r2, lat);
        model(1'b0, xa, ya, za, e1, e2);
        check("hs_a_res1", r1, e1);
        check("hs_a_res2", r2, e2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_res1", s16(res1), e1);
            check("stall_res2", s16(res2), e2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("ack_out_valid", int'(out_valid), 0);
        check("ack_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(r1, r2, lat);
        model(1'b1, xb, yb, 0, e1, e2);
        check("hs_b_lat", lat, LAT);
        check("hs_b_res1", r1, e1);
        check("hs_b_res2", r2, e2);
        ack();

        // Reset during RUN: no result afterwards, outputs cleared
        start_op(1'b0, 'h26DD, 0, 'h1922);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_out_valid", int'(out_valid), 0);
        check("mrst_res1", s16(res1), 0);
        check("mrst_res2", s16(res2), 0);
        check("mrst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid === 1'b1) n++;
        end
        check("mrst_stale", n, 0);
        check("mrst_idle", int'(in_ready), 1);

        // Randomized in-domain operations, both modes
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 0)
                run_op("rand_rot", 1'b0, int'($urandom_range(65535)) - 32768,
                       int'($urandom_range(65535)) - 32768,
                       int'($urandom_range(25734)) - 12867, r1, r2);
            else
                run_op("rand_vec", 1'b1, int'($urandom_range(32767)),
                       int'($urandom_range(65535)) - 32768,
                       int'($urandom_range(65535)) - 32768, r1, r2);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cordic_engine.md
Name: cordic_engine

Overview:
- Parametrised, iterative CORDIC core; successor to the fixed 16-bit `cordic` block.
- Supports rotation and vectoring modes with valid/ready handshakes on input and output.
- Sits between stimulus/host logic and downstream math consumers; one operation is in flight at a time.
- Width and iteration count are set by parameters.

Parameters:
- WIDTH, 16: width of x/y/z and results. x/y are signed Q2.(WIDTH-2); z/angle is signed Q3.(WIDTH-3) radians. Legal range 12..32.
- ITER, 14: micro-rotations per operation. Legal range 4..WIDTH.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: request valid.
- in_ready, out, 1: engine can accept a request.
- mode, in, 1: 0 = rotation, 1 = vectoring.
- x_in, in, WIDTH: signed x.
- y_in, in, WIDTH: signed y.
- z_in, in, WIDTH: signed angle; ignored in vectoring.
- out_valid, out, 1: results valid.
- out_ready, in, 1: consumer accepts results.
- res1, out, WIDTH: x_final in both modes.
- res2, out, WIDTH: y_final in rotation mode; z_final (angle) in vectoring mode.

Behaviour:
- Reset values:
  - state = IDLE, out_valid = 0, res1 = res2 = 0, iteration counter = 0.
  - in_ready = 0 while reset is high.
  - Reset asserted mid-operation aborts the operation with no output.
- FSM states: IDLE, RUN, DONE (plus NORM when the optional feature is on).
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch mode; load x, y sign-extended to WIDTH+2 internal bits; load z; clear counter i; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle performs micro-rotation i:
    - d = sign(z) in rotation mode; d = -sign(y) in vectoring mode. Zero counts as positive.
    - x' = x - d·(y>>>i); y' = y + d·(x>>>i); z' = z - d·atan(2^-i).
  - Shifts are arithmetic. i increments each cycle; after i = ITER-1, go to DONE.
- DONE:
  - out_valid = 1; res1/res2 are driven from registers and held stable until out_ready.
  - On out_valid & out_ready: go to IDLE, out_valid = 0.
- Latency and throughput:
  - Acceptance edge t0 → out_valid high in the cycle after edge t0+ITER.
  - Maximum throughput is one operation per ITER+2 cycles.
  - No back-to-back acceptance while DONE is waiting on out_ready.
- Arithmetic:
  - Internal x/y datapath is WIDTH+2 bits to absorb CORDIC gain (~1.6468).
  - Results saturate to the signed WIDTH range: max 2^(WIDTH-1)-1, min -2^(WIDTH-1). No wrap.
  - z is WIDTH+1 bits internal, truncated (not saturated) on output.
- Domain:
  - Rotation requires |z_in| ≤ π/2.
  - Vectoring requires x_in ≥ 0.
  - No quadrant pre-rotation. Out-of-domain inputs give deterministic, iteration-defined results that are not mathematically meaningful.
- Simultaneous events:
  - in_valid while not IDLE is ignored; the requester holds it.
  - out_ready without out_valid has no effect.
  - Inputs are sampled only at the acceptance edge; changes during RUN have no effect.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined:
  - After RUN, a NORM state (1 cycle) multiplies x_final (and y_final in rotation mode) by 1/K from the package (Q1.(WIDTH+2)), rounding half-up, then saturates.
  - Latency becomes ITER+2.
- Undefined:
  - Results carry gain K ≈ 1.6468; no NORM state; latency ITER+1.

Decomposition:
- Package cordic_pkg:
  - 32-entry atan(2^-i) table, Q3.29; entry used = table[i] >>> (32-WIDTH) with rounding.
  - Mode encodings MODE_ROT = 0, MODE_VEC = 1.
  - State enum.
  - Constant INV_GAIN (1/K ≈ 0.607253).
- Sub-module cordic_iter_step: combinational single micro-rotation.
  - Inputs: x, y, z, i, mode.
  - Outputs: x', y', z'.
  - Instantiated once, reused each RUN cycle.

Test Plan (WIDTH=16, ITER=14, no gain-comp; tolerance ±4 LSB):
- Rotation, x=0x26DD (1/K), y=0, z=0 → res1≈0x4000, res2≈0x0000; out_valid exactly 15 cycles after acceptance.
- Rotation, x=0x26DD, y=0, z=0x1922 (π/4) → res1≈0x2D41, res2≈0x2D41.
- Vectoring, x=0x2000, y=0x2000 → res1≈0x4A86, res2≈0x1922.
- Vectoring, x=0x4000, y=0x4000 → res1 saturates to 0x7FFF; res2≈0x1922.
- Handshake: hold out_ready=0 for 10 cycles → res1/res2/out_valid stable and in_ready=0 throughout. Pulse in_valid during RUN → ignored; the next acceptance occurs only after the DONE handshake.
- Reset asserted in mid-RUN (cycle 5) → next cycle out_valid=0, res1=res2=0, state IDLE; no stale result appears afterwards.
